// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, stall FSM and bubble insertion.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module id_ex_stage #(
    parameter int DATA_W   = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IF_ID_Valid,
    input  logic [4:0]        IF_ID_Rs1,
    input  logic [4:0]        IF_ID_Rs2,
    input  logic [4:0]        IF_ID_Rd,
    input  logic [7:0]        IF_ID_Ctrl,
    input  logic [3:0]        IF_ID_Funct,
    input  logic [DATA_W-1:0] IF_ID_RD1,
    input  logic [DATA_W-1:0] IF_ID_RD2,
    input  logic [DATA_W-1:0] IF_ID_Imm,
    input  logic [DATA_W-1:0] IF_ID_PC,
    input  logic              flush,
    input  logic              ex_busy,
    output logic [4:0]        ID_EX_Rs1,
    output logic [4:0]        ID_EX_Rs2,
    output logic [4:0]        ID_EX_Rd,
    output logic [7:0]        ID_EX_Ctrl,
    output logic [3:0]        ID_EX_Funct,
    output logic [DATA_W-1:0] ID_EX_RD1,
    output logic [DATA_W-1:0] ID_EX_RD2,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic [DATA_W-1:0] ID_EX_PC,
    output logic              PCWrite,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       stall_cycles,
`endif
    output logic              IF_ID_Write
);

    localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    typedef struct packed {
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [7:0]        ctrl;
        logic [3:0]        funct;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
    } idex_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    idex_t      idex_q, idex_d;
    idex_t      in_pkt;
    logic       hazard;
    logic       stall;

    assign in_pkt = '{rs1: IF_ID_Rs1, rs2: IF_ID_Rs2, rd: IF_ID_Rd, ctrl: IF_ID_Ctrl,
                      funct: IF_ID_Funct, rd1: IF_ID_RD1, rd2: IF_ID_RD2,
                      imm: IF_ID_Imm, pc: IF_ID_PC};

    // Rs2 is compared for every format on purpose: a spurious stall is harmless.
    assign hazard = IF_ID_Valid & idex_q.ctrl[6] & (idex_q.rd != 5'd0) &
                    ((idex_q.rd == IF_ID_Rs1) | (idex_q.rd == IF_ID_Rs2));

    assign stall = rst_n & ~flush &
                   (ex_busy | ((state_q == RUN) & hazard) | (state_q == STALL));

    always_comb begin
        idex_d  = idex_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            idex_d  = '0;
            state_d = RUN;
            cnt_d   = '0;
        end else if (!ex_busy) begin
            if (state_q == STALL) begin
                idex_d = '0;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RUN;
            end else if (hazard) begin
                idex_d = '0;
                if (LOAD_LAT > 1) begin
                    state_d = STALL;
                    cnt_d   = LAT_M1;
                end
            end else begin
                idex_d = IF_ID_Valid ? in_pkt : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            idex_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idex_q  <= idex_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles_q <= '0;
        else        stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

    assign ID_EX_Rs1   = idex_q.rs1;
    assign ID_EX_Rs2   = idex_q.rs2;
    assign ID_EX_Rd    = idex_q.rd;
    assign ID_EX_Ctrl  = idex_q.ctrl;
    assign ID_EX_Funct = idex_q.funct;
    assign ID_EX_RD1   = idex_q.rd1;
    assign ID_EX_RD2   = idex_q.rd2;
    assign ID_EX_Imm   = idex_q.imm;
    assign ID_EX_PC    = idex_q.pc;
    assign PCWrite     = ~stall;
    assign IF_ID_Write = ~stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: instance 0 uses LOAD_LAT=1, instance 1 uses LOAD_LAT=3.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic [3:0]  funct;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
    } inst_t;

    typedef struct {
        int d;
        int id;
        bit pcw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic        v[2];
    logic [4:0]  rs1[2], rs2[2], rd[2];
    logic [7:0]  ctrl[2];
    logic [3:0]  funct[2];
    logic [31:0] rd1[2], rd2[2], imm[2], pc[2];
    logic        fl[2], bz[2];
    logic [4:0]  o_rs1[2], o_rs2[2], o_rd[2];
    logic [7:0]  o_ctrl[2];
    logic [3:0]  o_funct[2];
    logic [31:0] o_rd1[2], o_rd2[2], o_imm[2], o_pc[2];
    logic        o_pcw[2], o_ifw[2];
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] o_sc[2];
    logic [31:0] sc_snap[2];
`endif

    exp_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        id_ex_stage #(.DATA_W(32), .LOAD_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .IF_ID_Valid(v[g]), .IF_ID_Rs1(rs1[g]), .IF_ID_Rs2(rs2[g]), .IF_ID_Rd(rd[g]),
            .IF_ID_Ctrl(ctrl[g]), .IF_ID_Funct(funct[g]),
            .IF_ID_RD1(rd1[g]), .IF_ID_RD2(rd2[g]), .IF_ID_Imm(imm[g]), .IF_ID_PC(pc[g]),
            .flush(fl[g]), .ex_busy(bz[g]),
            .ID_EX_Rs1(o_rs1[g]), .ID_EX_Rs2(o_rs2[g]), .ID_EX_Rd(o_rd[g]),
            .ID_EX_Ctrl(o_ctrl[g]), .ID_EX_Funct(o_funct[g]),
            .ID_EX_RD1(o_rd1[g]), .ID_EX_RD2(o_rd2[g]), .ID_EX_Imm(o_imm[g]), .ID_EX_PC(o_pc[g]),
            .PCWrite(o_pcw[g]),
`ifdef HAZARD_PERF_CNT_EN
            .stall_cycles(o_sc[g]),
`endif
            .IF_ID_Write(o_ifw[g])
        );
    end

    // Instruction table; id 0 is an idle slot carrying junk fields with valid low.
    function automatic inst_t tab(input int id);
        inst_t t;
        case (id)
            1: t = '{1'b1, 5'd1, 5'd3, 5'd5, 8'hD4, 4'h2, 32'h100, 32'h33, 32'h4, 32'h10};  // lw x5
            2: t = '{1'b1, 5'd5, 5'd7, 5'd6, 8'h82, 4'h0, 32'h11, 32'h22, 32'h0, 32'h14};  // add x6,x5,x7
            3: t = '{1'b1, 5'd1, 5'd3, 5'd0, 8'hD4, 4'h2, 32'h200, 32'h44, 32'h8, 32'h18}; // lw x0
            4: t = '{1'b1, 5'd0, 5'd0, 5'd6, 8'h82, 4'h0, 32'h0, 32'h0, 32'h0, 32'h1C};    // add x6,x0,x0
            6: t = '{1'b1, 5'd1, 5'd2, 5'd6, 8'h82, 4'h0, 32'h55, 32'h66, 32'h0, 32'h24};  // add x6,x1,x2
            7: t = '{1'b1, 5'd9, 5'd10, 5'd8, 8'h82, 4'h8, 32'h77, 32'h88, 32'h0, 32'h28}; // sub x8,x9,x10
            8: t = '{1'b1, 5'd7, 5'd5, 5'd11, 8'h82, 4'h0, 32'h99, 32'hAA, 32'h0, 32'h2C}; // add x11,x7,x5
            default: t = '{1'b0, 5'd5, 5'd5, 5'd9, 8'hFF, 4'hF, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'hFFFFFFF0};
        endcase
        return t;
    endfunction

    function automatic logic [154:0] exp_vec(input int id);
        inst_t t = tab(id);
        if (id == 0) return '0;
        return {t.rs1, t.rs2, t.rd, t.ctrl, t.funct, t.rd1, t.rd2, t.imm, t.pc};
    endfunction

    task automatic drive(input int d, input int id, input bit f, input bit b, input int eid, input bit epcw);
        inst_t t = tab(id);
        v[d] = t.valid; rs1[d] = t.rs1; rs2[d] = t.rs2; rd[d] = t.rd;
        ctrl[d] = t.ctrl; funct[d] = t.funct;
        rd1[d] = t.rd1; rd2[d] = t.rd2; imm[d] = t.imm; pc[d] = t.pc;
        fl[d] = f; bz[d] = b;
        sb.push_back('{d: d, id: eid, pcw: epcw});
    endtask

    task automatic both(input int id, input bit f, input bit b, input int eid, input bit epcw);
        drive(0, id, f, b, eid, epcw);
        drive(1, id, f, b, eid, epcw);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: ID_EX_* and PCWrite are presented every cycle; check mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [154:0] act;
            e = sb.pop_front();
            act = {o_rs1[e.d], o_rs2[e.d], o_rd[e.d], o_ctrl[e.d], o_funct[e.d],
                   o_rd1[e.d], o_rd2[e.d], o_imm[e.d], o_pc[e.d]};
            n_chk++;
            if (act !== exp_vec(e.id)) begin
                n_fail++;
                $display("FAIL idex dut%0d t=%0t got=%h want=%h (inst %0d)", e.d, $time, act, exp_vec(e.id), e.id);
            end
            n_chk++;
            if ({o_pcw[e.d], o_ifw[e.d]} !== {e.pcw, e.pcw}) begin
                n_fail++;
                $display("FAIL pcwrite dut%0d t=%0t got PCWrite=%b IF_ID_Write=%b want=%b",
                         e.d, $time, o_pcw[e.d], o_ifw[e.d], e.pcw);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v[d] = 0; rs1[d] = 0; rs2[d] = 0; rd[d] = 0; ctrl[d] = 0; funct[d] = 0;
            rd1[d] = 0; rd2[d] = 0; imm[d] = 0; pc[d] = 0; fl[d] = 0; bz[d] = 0;
        end
        // Reset held with live input and ex_busy: stay bubble, PCWrite high
        repeat (2) begin nxt(); both(1, 0, 1, 0, 1); end
        nxt(); rst_n = 1'b1; both(0, 0, 0, 0, 1);
        nxt(); both(0, 0, 0, 0, 1);

        // lw x5 ; add x6,x5,x7 : one bubble on dut0, three on dut1
        nxt(); drive(0, 1, 0, 0, 0, 1); drive(1, 1, 0, 0, 0, 1);
        nxt(); drive(0, 2, 0, 0, 1, 0); drive(1, 2, 0, 0, 1, 0);
        nxt(); drive(0, 2, 0, 0, 0, 1); drive(1, 2, 0, 0, 0, 0);
        nxt(); drive(0, 0, 0, 0, 2, 1); drive(1, 2, 0, 0, 0, 0);
        nxt(); drive(0, 0, 0, 0, 0, 1); drive(1, 2, 0, 0, 0, 1);
        nxt(); drive(0, 0, 0, 0, 0, 1); drive(1, 0, 0, 0, 2, 1);
        nxt(); both(0, 0, 0, 0, 1);

        // dut0: hazard via Rs2 ; dut1: flush in second STALL cycle
        nxt(); drive(0, 1, 0, 0, 0, 1); drive(1, 1, 0, 0, 0, 1);
        nxt(); drive(0, 8, 0, 0, 1, 0); drive(1, 2, 0, 0, 1, 0);
        nxt(); drive(0, 8, 0, 0, 0, 1); drive(1, 2, 0, 0, 0, 0);
        nxt(); drive(0, 0, 0, 0, 8, 1); drive(1, 2, 1, 0, 0, 1);
        nxt(); drive(0, 0, 0, 0, 0, 1); drive(1, 7, 0, 0, 0, 1);
        nxt(); drive(0, 0, 0, 0, 0, 1); drive(1, 0, 0, 0, 7, 1);
        nxt(); both(0, 0, 0, 0, 1);

        // No hazard: lw x0 then x0 user; lw x5 then unrelated add
        nxt(); both(3, 0, 0, 0, 1);
        nxt(); both(4, 0, 0, 3, 1);
        nxt(); both(1, 0, 0, 4, 1);
        nxt(); both(6, 0, 0, 1, 1);
        nxt(); both(0, 0, 0, 6, 1);
        nxt(); both(0, 0, 0, 0, 1);

        // ex_busy for two cycles holds contents; flush beats ex_busy
        nxt(); both(7, 0, 0, 0, 1);
        nxt(); both(8, 0, 1, 7, 0);
`ifdef HAZARD_PERF_CNT_EN
        sc_snap[0] = o_sc[0]; sc_snap[1] = o_sc[1];
`endif
        nxt(); both(8, 0, 1, 7, 0);
        nxt(); both(8, 0, 0, 7, 1);
`ifdef HAZARD_PERF_CNT_EN
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (o_sc[d] !== sc_snap[d] + 32'd2) begin
                n_fail++;
                $display("FAIL stall_cycles dut%0d got=%0d want=%0d", d, o_sc[d], sc_snap[d] + 32'd2);
            end
        end
`endif
        nxt(); both(6, 1, 1, 8, 1);
        nxt(); both(0, 0, 0, 0, 1);

        // Reset asserted while dut1 is in STALL
        nxt(); both(1, 0, 0, 0, 1);
        nxt(); both(2, 0, 0, 1, 0);
        nxt(); rst_n = 1'b0; both(2, 0, 0, 0, 1);
        nxt(); both(2, 0, 1, 0, 1);
        nxt(); rst_n = 1'b1; both(2, 0, 0, 0, 1);
        nxt(); both(0, 0, 0, 2, 1);
        nxt(); both(0, 0, 0, 0, 1);

        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
